// File: rtl/store_lane_packer_if.sv
// Store request / memory request bundle for store_lane_packer.
//   master : the MEM-stage and memory side (drives st_*, mem_addr_ok)
//   slave  : the packer (drives st_ready/st_err/st_badvaddr, mem_*, sb_*)
interface store_lane_packer_if #(
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [1:0]       st_size;
  logic             st_err;
  logic [31:0]      st_badvaddr;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_addr_ok;
  logic             sb_empty;
  logic [CNT_W-1:0] sb_count;

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_addr_ok,
    input  st_ready, st_err, st_badvaddr, mem_req, mem_addr, mem_wdata,
           mem_wstrb, sb_empty, sb_count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_addr_ok,
    output st_ready, st_err, st_badvaddr, mem_req, mem_addr, mem_wdata,
           mem_wstrb, sb_empty, sb_count
  );
endinterface

// File: rtl/store_lane_packer.sv
// Store lane packer: narrows a register value to byte/half/word, replicates
// it across byte lanes with a write strobe, and drains it in order to the
// data-SRAM port from a small circular store buffer.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : store request in (st_*), memory request out (mem_*),
//            buffer status (sb_empty, sb_count)
module store_lane_packer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  store_lane_packer_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sb_entry_t;

  sb_entry_t              entries_q [DEPTH];
  sb_entry_t              entries_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   err_q, err_d;
  logic [31:0]            badvaddr_q, badvaddr_d;

  logic                   ready_c;
  logic                   req_c;
  logic                   take_c;
  logic                   fault_c;
  logic                   push_c;
  logic                   pop_c;
  sb_entry_t              new_c;
  sb_entry_t              head_c;

  // Buffer status decoded purely from the registered count.
  assign ready_c = (count_q != CNT_W'(DEPTH));
  assign req_c   = (count_q != '0);
  assign head_c  = entries_q[rd_ptr_q];

  // Alignment check, lane packing and pointer/count next state.
  always_comb begin
    fault_c    = 1'b0;
    new_c      = '0;
    entries_d  = entries_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_d      = 1'b0;
    badvaddr_d = '0;

    take_c = bus.st_valid && ready_c;
    pop_c  = req_c && bus.mem_addr_ok;

    new_c.waddr = bus.st_addr[31:2];
    unique case (bus.st_size)
      2'b00: begin
        new_c.wdata = {4{bus.st_data[7:0]}};
        new_c.wstrb = 4'b0001 << bus.st_addr[1:0];
      end
      2'b01: begin
        fault_c     = bus.st_addr[0];
        new_c.wdata = {2{bus.st_data[15:0]}};
        new_c.wstrb = bus.st_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        fault_c     = (bus.st_addr[1:0] != 2'b00);
        new_c.wdata = bus.st_data;
        new_c.wstrb = 4'b1111;
      end
      default: begin
        fault_c = 1'b1;
      end
    endcase

    push_c = take_c && !fault_c;

    // Faulting store completes the handshake but only raises the error pulse.
    if (take_c && fault_c) begin
      err_d      = 1'b1;
      badvaddr_d = bus.st_addr;
    end

    if (push_c) begin
      entries_d[wr_ptr_q] = new_c;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Control state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      badvaddr_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // Entry storage; contents are only visible while the entry is occupied.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  // Head outputs are forced to zero while the buffer is empty, so a reset
  // clears them along with the count.
  assign bus.st_ready    = ready_c;
  assign bus.st_err      = err_q;
  assign bus.st_badvaddr = badvaddr_q;
  assign bus.mem_req     = req_c;
  assign bus.mem_addr    = req_c ? {head_c.waddr, 2'b00} : '0;
  assign bus.mem_wdata   = req_c ? head_c.wdata : '0;
  assign bus.mem_wstrb   = req_c ? head_c.wstrb : '0;
  assign bus.sb_empty    = !req_c;
  assign bus.sb_count    = count_q;
endmodule

// File: tb/tb_store_lane_packer.sv
// Self-checking bench for store_lane_packer: directed steps plus random
// traffic compared against a queue-based model of the store buffer.
module tb_store_lane_packer;
  localparam int unsigned DEPTH = 2;

  logic clk;
  logic resetn;

  store_lane_packer_if #(.DEPTH(DEPTH)) bus ();

  store_lane_packer #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } exp_t;

  exp_t        q [$];
  logic        exp_err;
  logic [31:0] exp_bad;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t pack(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    exp_t e;
    e.addr  = {a[31:2], 2'b00};
    e.wdata = '0;
    e.strb  = '0;
    for (int i = 0; i < 4; i++) begin
      case (s)
        2'b00: begin
          e.wdata[8*i +: 8] = d[7:0];
          e.strb[i]         = (i == int'(a[1:0]));
        end
        2'b01: begin
          e.wdata[8*i +: 8] = d[8*(i%2) +: 8];
          e.strb[i]         = ((i / 2) == int'(a[1]));
        end
        default: begin
          e.wdata[8*i +: 8] = d[8*i +: 8];
          e.strb[i]         = 1'b1;
        end
      endcase
    end
    return e;
  endfunction

  function automatic bit is_fault(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
  endfunction

  // Compare all outputs against the model's current state.
  task automatic check_all();
    exp_t h;
    bit   req_e;
    req_e = (q.size() != 0);
    h.addr = '0; h.wdata = '0; h.strb = '0;
    if (req_e) h = q[0];
    chk("st_ready",    32'(bus.st_ready),    32'(q.size() < DEPTH));
    chk("mem_req",     32'(bus.mem_req),     32'(req_e));
    chk("sb_empty",    32'(bus.sb_empty),    32'(!req_e));
    chk("sb_count",    32'(bus.sb_count),    32'(q.size()));
    chk("mem_addr",    bus.mem_addr,         h.addr);
    chk("mem_wdata",   bus.mem_wdata,        h.wdata);
    chk("mem_wstrb",   32'(bus.mem_wstrb),   32'(h.strb));
    chk("st_err",      32'(bus.st_err),      32'(exp_err));
    chk("st_badvaddr", bus.st_badvaddr,      exp_bad);
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input bit ok);
    bit acc, pop;
    @(negedge clk);
    check_all();
    bus.st_valid    = v;
    bus.st_addr     = a;
    bus.st_data     = d;
    bus.st_size     = s;
    bus.mem_addr_ok = ok;
    acc = v && (q.size() < DEPTH);
    pop = (q.size() != 0) && ok;
    if (pop) void'(q.pop_front());
    exp_err = acc && is_fault(a, s);
    exp_bad = exp_err ? a : 32'h0;
    if (acc && !is_fault(a, s)) q.push_back(pack(a, d, s));
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic [1:0]  rs;
    n_cmp = 0;
    n_bad = 0;
    exp_err = 1'b0;
    exp_bad = '0;
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.st_size = 2'b00; bus.mem_addr_ok = 1'b0;

    // Reset state
    resetn = 1'b0;
    #3;
    check_all();
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Byte store to lane 3, drained immediately
    cycle(1, 32'h1000_0003, 32'hAABB_CCDD, 2'b00, 1);
    after_edge();
    chk("tp_sb_req",   32'(bus.mem_req), 32'd1);
    chk("tp_sb_addr",  bus.mem_addr,     32'h1000_0000);
    chk("tp_sb_wdata", bus.mem_wdata,    32'hDDDD_DDDD);
    chk("tp_sb_wstrb", 32'(bus.mem_wstrb), 32'b1000);
    cycle(0, 0, 0, 2'b00, 1);
    after_edge();
    chk("tp_sb_empty", 32'(bus.sb_empty), 32'd1);

    // Halfword and word packing
    cycle(1, 32'h0000_0006, 32'h1234_5678, 2'b01, 0);
    after_edge();
    chk("tp_sh_wdata", bus.mem_wdata, 32'h5678_5678);
    chk("tp_sh_wstrb", 32'(bus.mem_wstrb), 32'b1100);
    cycle(1, 32'h0000_0008, 32'h1234_5678, 2'b10, 1);
    cycle(0, 0, 0, 2'b00, 0);
    after_edge();
    chk("tp_sw_wdata", bus.mem_wdata, 32'h1234_5678);
    chk("tp_sw_wstrb", 32'(bus.mem_wstrb), 32'b1111);
    cycle(0, 0, 0, 2'b00, 1);

    // Misaligned word, then illegal size: one-cycle fault pulses
    cycle(1, 32'h0000_0002, 32'hDEAD_BEEF, 2'b10, 0);
    after_edge();
    chk("tp_mis_err", 32'(bus.st_err), 32'd1);
    chk("tp_mis_bad", bus.st_badvaddr, 32'h0000_0002);
    chk("tp_mis_req", 32'(bus.mem_req), 32'd0);
    chk("tp_mis_cnt", 32'(bus.sb_count), 32'd0);
    cycle(1, 32'h0000_0000, 32'h0, 2'b11, 0);
    after_edge();
    chk("tp_ill_err", 32'(bus.st_err), 32'd1);
    chk("tp_ill_bad", bus.st_badvaddr, 32'h0);
    cycle(0, 0, 0, 2'b00, 0);
    after_edge();
    chk("tp_err_pulse", 32'(bus.st_err), 32'd0);

    // Fill with memory stalled; third store held until a pop frees space
    cycle(1, 32'h0000_0100, 32'h1111_1111, 2'b10, 0);
    cycle(1, 32'h0000_0104, 32'h2222_2222, 2'b10, 0);
    cycle(1, 32'h0000_0108, 32'h3333_3333, 2'b10, 0);
    after_edge();
    chk("tp_full_ready", 32'(bus.st_ready), 32'd0);
    cycle(1, 32'h0000_0108, 32'h3333_3333, 2'b10, 1);
    after_edge();
    chk("tp_pop_ready", 32'(bus.st_ready), 32'd1);
    chk("tp_pop_head",  bus.mem_addr, 32'h0000_0104);
    cycle(1, 32'h0000_0108, 32'h3333_3333, 2'b10, 0);
    repeat (3) cycle(0, 0, 0, 2'b00, 1);

    // Streaming with memory always ready
    for (int i = 0; i < 8; i++) begin
      rs = 2'($urandom_range(0, 2));
      ra = $urandom & ~((32'd1 << rs) - 32'd1);
      cycle(1, ra, $urandom, rs, 1);
    end
    cycle(0, 0, 0, 2'b00, 1);

    // Asynchronous reset with two entries held
    cycle(1, 32'h0000_0200, 32'hCAFE_F00D, 2'b10, 0);
    cycle(1, 32'h0000_0205, 32'h0000_00AB, 2'b00, 0);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_req",   32'(bus.mem_req), 32'd0);
    chk("rst_cnt",   32'(bus.sb_count), 32'd0);
    chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
    q.delete();
    exp_err = 1'b0;
    exp_bad = '0;
    bus.st_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) cycle(0, 0, 0, 2'b00, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
      rd = $urandom;
      cycle(bit'($urandom_range(0, 1)), ra, rd, rs, bit'($urandom_range(0, 2) != 0));
    end
    repeat (4) cycle(0, 0, 0, 2'b00, 1);
    @(negedge clk);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/store_lane_packer.md
# store_lane_packer

Store-side data path unit between the MEM stage and the data-SRAM request port: narrows a 32-bit register value to byte, halfword or word, replicates it onto the correct byte lanes and generates the 4-bit write strobe. It is the inverse of the immediate and load widening path. Accepted stores sit in a small in-order buffer and drain to memory through a valid/accept handshake. Misaligned or illegal-size stores are flagged instead of written.

## Interface
- DEPTH, 2, store buffer entries; power of two, at least 2
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  buffer can accept; equals !full
- st_addr  in  32  byte address
- st_data  in  32  register value; low bits used for byte and half
- st_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- st_err  out  1  one-cycle pulse: previous accepted store was misaligned or illegal
- st_badvaddr  out  32  address of the faulting store; valid while st_err=1
- mem_req  out  1  head entry valid
- mem_addr  out  32  word address; bits [1:0] always 00
- mem_wdata  out  32  lane-replicated data
- mem_wstrb  out  4  byte enables
- mem_addr_ok  in  1  memory accepts the current request
- sb_empty  out  1  buffer empty; used by the load path for ordering
- sb_count  out  log2(DEPTH)+1  occupied entries

## Operation
- Handshake in: a store is taken when st_valid && st_ready.
- Alignment check on the taken store:
  - halfword faults if addr[0]=1
  - word faults if addr[1:0]!=00
  - size 11 always faults
  - byte never faults
- A faulting store completes the handshake but is not enqueued. st_err=1 and st_badvaddr=st_addr on the next cycle only.
- Packing, computed at enqueue and stored in the entry:
  - byte: wdata={4{data[7:0]}}, wstrb=0001<<addr[1:0]
  - half: wdata={2{data[15:0]}}, wstrb = addr[1] ? 1100 : 0011
  - word: wdata=data, wstrb=1111
  - mem_addr={addr[31:2],2'b00} in all cases
- Buffer is a circular FIFO with read and write pointers wrapping modulo DEPTH. Count saturates neither way; overflow and underflow are impossible by the handshake rules.
- Drain: mem_req=!sb_empty, and mem_addr/wdata/wstrb come from the head entry. The head is popped when mem_req && mem_addr_ok.
- While mem_req=1, the head outputs are held stable until accepted.
- Strict program order is kept; there is no merging or forwarding.

## Timing
- Reset (resetn=0, asynchronous) drives:
  - st_ready=1, st_err=0, st_badvaddr=0
  - mem_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0
  - sb_empty=1, sb_count=0, pointers=0
- A reset mid-operation discards all buffered stores immediately; mem_req falls asynchronously.
- Enqueue latency: a store accepted at edge N produces mem_req=1 in the cycle after edge N if the buffer was empty (one cycle).
- st_ready depends only on registered count. There is no combinational path from mem_addr_ok to st_ready.
- When full, st_ready=0 even in a cycle where mem_addr_ok pops the head. The next cycle st_ready=1.
- Simultaneous enqueue and dequeue when not full: count is unchanged, both pointers advance.
- Simultaneous faulting store and dequeue: only the dequeue changes state, and st_err pulses the next cycle.
- Back-to-back stores with mem_addr_ok held at 1 sustain one store per cycle.
- All outputs are registered or decoded from registers. The only combinational input is mem_addr_ok, which feeds the pop logic.

## Test plan
- Reset, then sb (st_size=00), addr=0x1000_0003, data=0xAABB_CCDD, mem_addr_ok=1 -> next cycle mem_req=1, mem_addr=0x1000_0000, mem_wdata=0xDDDD_DDDD, mem_wstrb=1000; after pop, sb_empty=1.
- sh to 0x0000_0006 with data 0x1234_5678 -> wdata=0x5678_5678, wstrb=1100. sw to 0x0000_0008 -> wdata=data, wstrb=1111.
- sw to 0x0000_0002 -> st_err=1 for exactly one cycle with st_badvaddr=0x0000_0002, mem_req stays 0, sb_count=0. Repeat with st_size=11 to 0x0 -> same fault.
- mem_addr_ok=0, issue 3 back-to-back stores with DEPTH=2 -> st_ready=0 after the 2nd and the 3rd is held. Raise mem_addr_ok for one cycle -> st_ready=1 on the following cycle (not the same one), 3rd accepted, order preserved.
- Stream of 8 stores with mem_addr_ok=1 constantly -> one mem request per cycle, pointers wrap correctly, data order matches issue order.
- Buffer holding 2 entries, assert resetn=0 mid-cycle -> mem_req, sb_count and strobes clear immediately without a clock edge. After release, no stale request appears.
